sync_fifo: RTL and testbench

SYNC_FIFO -- requirements
Module: sync_fifo

---
 rtl/sync_fifo_pkg.sv | 18 +
 rtl/sync_fifo_ram.sv | 42 ++++
 rtl/sync_fifo.sv | 97 +++++++++
 tb/tb_sync_fifo.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared constants and width helpers for the synchronous FIFO.
//   DEFAULT_WIDTH / DEFAULT_DEPTH : default data width and number of entries
//   ptr_width(depth)              : bits needed for a pointer in 0..depth-1
//   cnt_width(depth)              : bits needed for an occupancy count in 0..depth
package sync_fifo_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam int unsigned DEFAULT_DEPTH = 4;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? int'($clog2(depth)) : 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned depth);
        return int'($clog2(depth + 1));
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Storage array for sync_fifo: DEPTH x WIDTH, synchronous write, asynchronous read.
// Every entry is cleared by the asynchronous active-low reset so the read port
// never returns X after reset.
//   clk     : write clock (rising edge)
//   reset   : asynchronous active-low clear of all entries
//   i_we    : write enable
//   i_waddr : write address (0..DEPTH-1)
//   i_wdata : write data
//   i_raddr : read address (0..DEPTH-1)
//   o_rdata : combinational read data at i_raddr
module sync_fifo_ram
    import sync_fifo_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned DEPTH  = DEFAULT_DEPTH,
    parameter int unsigned ADDR_W = ptr_width(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Addresses are kept below DEPTH by the controller, so no out-of-range read.
    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO controller.
// Pointers wrap by explicit compare so any DEPTH >= 2 works, including
// non-powers of two. Flags are decoded from the occupancy count register.
//   clk        : single clock, rising edge
//   reset      : asynchronous active-low reset (clears pointers, count and storage)
//   w_valid    : write request, accepted when not full
//   data_in    : write data
//   r_ready    : read request, accepted when not empty
//   data_out   : current head entry (valid before the popping edge)
//   fifo_full  : occupancy == DEPTH
//   fifo_empty : occupancy == 0
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             w_valid,
    input  logic [WIDTH-1:0] data_in,
    input  logic             r_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             fifo_full,
    output logic             fifo_empty
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);
    localparam int unsigned CNT_W = cnt_width(DEPTH);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic [PTR_W-1:0] w_wr_ptr_nxt;
    logic [PTR_W-1:0] w_rd_ptr_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_wr_en;
    logic             w_rd_en;

    assign fifo_full  = (r_count == CNT_FULL);
    assign fifo_empty = (r_count == '0);

    // Gating on the flags drops writes when full and reads when empty; this also
    // resolves the both-high corner cases (full -> read only, empty -> write only).
    assign w_wr_en = w_valid && !fifo_full;
    assign w_rd_en = r_ready && !fifo_empty;

    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_count_nxt  = r_count;

        if (w_wr_en) begin
            w_wr_ptr_nxt = (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
        end
        if (w_rd_en) begin
            w_rd_ptr_nxt = (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PTR_W'(1);
        end

        unique case ({w_wr_en, w_rd_en})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
        end
    end

    sync_fifo_ram #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_wr_en),
        .i_waddr (r_wr_ptr),
        .i_wdata (data_in),
        .i_raddr (r_rd_ptr),
        .o_rdata (data_out)
    );

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo with WIDTH=32, DEPTH=3.
module tb_sync_fifo;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 3;

    logic             clk;
    logic             reset;
    logic             w_valid;
    logic [WIDTH-1:0] data_in;
    logic             r_ready;
    logic [WIDTH-1:0] data_out;
    logic             fifo_full;
    logic             fifo_empty;

    int n_cmp;
    int n_err;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .w_valid    (w_valid),
        .data_in    (data_in),
        .r_ready    (r_ready),
        .data_out   (data_out),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] val);
        w_valid = 1'b1;
        data_in = val;
        tick();
        w_valid = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [31:0] exp);
        chk(tag, data_out, exp);
        r_ready = 1'b1;
        tick();
        r_ready = 1'b0;
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        reset   = 1'b1;
        w_valid = 1'b0;
        r_ready = 1'b0;
        data_in = '0;

        // Reset pulse between edges.
        #2;
        reset = 1'b0;
        #1;
        chk("rst_empty", {31'd0, fifo_empty}, 32'd1);
        chk("rst_full", {31'd0, fifo_full}, 32'd0);
        chk("rst_dout", data_out, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Fill to capacity; the fourth write must be dropped.
        for (int i = 0; i < 3; i++) begin
            chk("fill_notfull", {31'd0, fifo_full}, 32'd0);
            push(32'(i));
        end
        chk("fill_full", {31'd0, fifo_full}, 32'd1);
        chk("fill_head", data_out, 32'd0);
        push(32'd3);
        chk("fill_full_after_drop", {31'd0, fifo_full}, 32'd1);

        // Drain: head visible before each popping edge.
        for (int i = 0; i < 3; i++) begin
            pop_check("drain_data", 32'(i));
        end
        chk("drain_empty", {31'd0, fifo_empty}, 32'd1);
        chk("drain_notfull", {31'd0, fifo_full}, 32'd0);

        // Wrap: four rounds, pointers pass DEPTH-1 -> 0 repeatedly.
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 3; k++) push(32'(3 * r + k));
            chk("wrap_full", {31'd0, fifo_full}, 32'd1);
            for (int k = 0; k < 3; k++) pop_check("wrap_data", 32'(3 * r + k));
            chk("wrap_empty", {31'd0, fifo_empty}, 32'd1);
        end

        // Simultaneous access at count=1: count holds, head advances.
        push(32'd100);
        chk("sim1_head", data_out, 32'd100);
        w_valid = 1'b1;
        r_ready = 1'b1;
        data_in = 32'd101;
        tick();
        w_valid = 1'b0;
        r_ready = 1'b0;
        chk("sim1_notempty", {31'd0, fifo_empty}, 32'd0);
        chk("sim1_notfull", {31'd0, fifo_full}, 32'd0);
        chk("sim1_head2", data_out, 32'd101);

        // Full with both high: read only, write dropped.
        push(32'd102);
        push(32'd103);
        chk("simf_full", {31'd0, fifo_full}, 32'd1);
        w_valid = 1'b1;
        r_ready = 1'b1;
        data_in = 32'd104;
        tick();
        w_valid = 1'b0;
        r_ready = 1'b0;
        chk("simf_fulldrop", {31'd0, fifo_full}, 32'd0);
        pop_check("simf_d0", 32'd102);
        pop_check("simf_d1", 32'd103);
        chk("simf_empty", {31'd0, fifo_empty}, 32'd1);

        // Empty with both high: write only.
        w_valid = 1'b1;
        r_ready = 1'b1;
        data_in = 32'd105;
        tick();
        chk("sime_notempty", {31'd0, fifo_empty}, 32'd0);
        chk("sime_head", data_out, 32'd105);
        data_in = 32'd106;
        tick();
        w_valid = 1'b0;
        r_ready = 1'b0;
        chk("sime_head2", data_out, 32'd106);
        pop_check("sime_last", 32'd106);
        chk("sime_empty", {31'd0, fifo_empty}, 32'd1);

        // Mid-operation reset with count=2, asserted between edges.
        push(32'd200);
        push(32'd201);
        chk("mid_pre_head", data_out, 32'd200);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_empty_now", {31'd0, fifo_empty}, 32'd1);
        chk("mid_full_now", {31'd0, fifo_full}, 32'd0);
        chk("mid_dout_now", data_out, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk("mid_post_empty", {31'd0, fifo_empty}, 32'd1);
        chk("mid_post_dout", data_out, 32'd0);
        push(32'd300);
        chk("mid_resume_head", data_out, 32'd300);
        pop_check("mid_resume_pop", 32'd300);
        chk("mid_resume_empty", {31'd0, fifo_empty}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
